// File: rtl/credit_pkt_bridge.sv
// credit_pkt_bridge
// Bridges a credit-flow-controlled request beat stream into a credit-flow-
// controlled response beat stream through a DEPTH-entry circular buffer.
// PKT_MODE=0 forwards beats cut-through. PKT_MODE=1 holds beats until a
// complete packet (LAST beat) is buffered, or until the buffer is full.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   req_val/data/last : upstream beat (no backpressure, credit governed)
//   req_credit        : one-cycle pulse returning one upstream credit
//   rsp_val/cmd/data  : downstream beat; cmd 01 DATA, 10 LAST, 00 idle
//   rsp_credit        : one-cycle pulse returning one downstream credit
//   fill              : buffer occupancy
//   err_ovf, err_cred : sticky protocol-error flags
module credit_pkt_bridge #(
  parameter int DATA_W      = 64,
  parameter int DEPTH       = 8,
  parameter int RSP_CREDITS = 4,
  parameter int PKT_MODE    = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_val,
  input  logic [DATA_W-1:0]        req_data,
  input  logic                     req_last,
  output logic                     req_credit,
  output logic                     rsp_val,
  output logic [1:0]               rsp_cmd,
  output logic [DATA_W-1:0]        rsp_data,
  input  logic                     rsp_credit,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     err_ovf,
  output logic                     err_cred
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DN_W  = $clog2(RSP_CREDITS) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [DN_W-1:0]  RSP_C   = DN_W'(RSP_CREDITS);

  typedef enum logic {WAIT = 1'b0, SEND = 1'b1} state_t;
  state_t state, state_nxt;

  logic [DATA_W:0]    mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   ret_cnt, up_cred, last_cnt;
  logic [CNT_W-1:0]   fill_nxt, last_cnt_nxt;
  logic [DN_W-1:0]    dn_cred;
  logic [DATA_W:0]    rd_entry;
  logic               accept, pop, pop_last, cred_issue, send_en;
  logic               cred_bad, cred_ok;

  // Upstream beats are only accepted against a credit already granted.
  assign accept     = req_val && (up_cred != '0);
  assign cred_issue = (ret_cnt != '0);
  assign rd_entry   = mem[rd_ptr];
  assign pop_last   = pop && rd_entry[DATA_W];
  // A downstream credit beyond the reset grant is a protocol error; it is
  // only legal at full count if a beat is consumed in the same cycle.
  assign cred_bad   = rsp_credit && (dn_cred == RSP_C) && !pop;
  assign cred_ok    = rsp_credit && !cred_bad;

  always_comb begin
    fill_nxt     = fill;
    last_cnt_nxt = last_cnt;
    if (accept && !pop)
      fill_nxt = fill + 1'b1;
    else if (!accept && pop)
      fill_nxt = fill - 1'b1;
    case ({accept && req_last, pop_last})
      2'b10:   last_cnt_nxt = last_cnt + 1'b1;
      2'b01:   last_cnt_nxt = last_cnt - 1'b1;
      default: last_cnt_nxt = last_cnt;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= WAIT;
    else
      state <= state_nxt;
  end

  // FSM: next state. In packet mode a full buffer with no LAST forces SEND,
  // otherwise an oversize packet could never complete.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT: begin
        if (PKT_MODE == 0) begin
          if (fill != '0) state_nxt = SEND;
        end else begin
          if ((last_cnt != '0) || (fill == DEPTH_C)) state_nxt = SEND;
        end
      end
      SEND: begin
        if (PKT_MODE == 0) begin
          if (fill_nxt == '0) state_nxt = WAIT;
        end else begin
          if (pop_last && (last_cnt_nxt == '0)) state_nxt = WAIT;
        end
      end
      default: state_nxt = WAIT;
    endcase
  end

  // FSM: outputs
  always_comb begin
    send_en = (state == SEND);
    pop     = send_en && (fill != '0) && (dn_cred != '0);
  end

  // Buffer storage; the slot freed by a same-cycle pop is reusable because
  // the credit loop never lets a write target an occupied entry.
  always_ff @(posedge clk) begin
    if (accept)
      mem[wr_ptr] <= {req_last, req_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill       <= '0;
      last_cnt   <= '0;
      ret_cnt    <= DEPTH_C;
      up_cred    <= '0;
      dn_cred    <= RSP_C;
      req_credit <= 1'b0;
      err_ovf    <= 1'b0;
      err_cred   <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      fill       <= fill_nxt;
      last_cnt   <= last_cnt_nxt;
      req_credit <= cred_issue;
      case ({pop, cred_issue})
        2'b10:   ret_cnt <= ret_cnt + 1'b1;
        2'b01:   ret_cnt <= ret_cnt - 1'b1;
        default: ret_cnt <= ret_cnt;
      endcase
      case ({req_credit, accept})
        2'b10:   up_cred <= up_cred + 1'b1;
        2'b01:   up_cred <= up_cred - 1'b1;
        default: up_cred <= up_cred;
      endcase
      case ({cred_ok, pop})
        2'b10:   dn_cred <= dn_cred + 1'b1;
        2'b01:   dn_cred <= dn_cred - 1'b1;
        default: dn_cred <= dn_cred;
      endcase
      if (req_val && (up_cred == '0)) err_ovf  <= 1'b1;
      if (cred_bad)                   err_cred <= 1'b1;
    end
  end

  // Output stage: popped beat registered onto the response port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_val  <= 1'b0;
      rsp_cmd  <= 2'b00;
      rsp_data <= '0;
    end else begin
      rsp_val <= pop;
      if (pop) begin
        rsp_cmd  <= rd_entry[DATA_W] ? 2'b10 : 2'b01;
        rsp_data <= rd_entry[DATA_W-1:0];
      end else begin
        rsp_cmd  <= 2'b00;
      end
    end
  end

endmodule
